// File: rtl/miriscv_decode_pkg.sv
// Decode-side constants shared by the pipeline: datapath widths and writeback source encodings.
package miriscv_decode_pkg;

    localparam int XLEN       = 32;
    localparam int GPR_ADDR_W = 5;
    localparam int WB_SRC_W   = 2;

    localparam logic [WB_SRC_W-1:0] ALU_DATA = 2'd0;
    localparam logic [WB_SRC_W-1:0] MDU_DATA = 2'd1;
    localparam logic [WB_SRC_W-1:0] LSU_DATA = 2'd2;

endpackage

// File: rtl/miriscv_lsu_pkg.sv
// Load/store unit definitions: access size encodings, FSM state type and lane helper functions.
package miriscv_lsu_pkg;

    import miriscv_decode_pkg::XLEN;

    localparam int MEM_ACCESS_W = 3;

    localparam logic [MEM_ACCESS_W-1:0] MEM_B  = 3'd0;
    localparam logic [MEM_ACCESS_W-1:0] MEM_H  = 3'd1;
    localparam logic [MEM_ACCESS_W-1:0] MEM_W  = 3'd2;
    localparam logic [MEM_ACCESS_W-1:0] MEM_BU = 3'd4;
    localparam logic [MEM_ACCESS_W-1:0] MEM_HU = 3'd5;

    typedef enum logic [1:0] {
        LSU_IDLE     = 2'd0,
        LSU_WAIT_GNT = 2'd1,
        LSU_WAIT_RSP = 2'd2
    } lsu_state_t;

    // Byte lane used by an access; halfwords honour only a[1], words always start at lane 0.
    function automatic logic [1:0] lane_offset(input logic [MEM_ACCESS_W-1:0] size, input logic [1:0] a);
        case (size[1:0])
            2'd0:    return a;
            2'd1:    return {a[1], 1'b0};
            default: return 2'b00;
        endcase
    endfunction

    function automatic logic is_misaligned(input logic [MEM_ACCESS_W-1:0] size, input logic [1:0] a);
        return ((size[1:0] == 2'd1) && a[0]) || ((size[1:0] == 2'd2) && (a != 2'b00));
    endfunction

    function automatic logic [XLEN/8-1:0] byte_enable(input logic [MEM_ACCESS_W-1:0] size, input logic [1:0] off);
        case (size[1:0])
            2'd0:    return 4'b0001 << off;
            2'd1:    return 4'b0011 << off;
            default: return 4'b1111;
        endcase
    endfunction

    function automatic logic [XLEN-1:0] store_data(input logic [MEM_ACCESS_W-1:0] size, input logic [XLEN-1:0] d);
        case (size[1:0])
            2'd0:    return {4{d[7:0]}};
            2'd1:    return {2{d[15:0]}};
            default: return d;
        endcase
    endfunction

    function automatic logic [XLEN-1:0] load_align(input logic [MEM_ACCESS_W-1:0] size, input logic [1:0] off,
                                                   input logic [XLEN-1:0] rdata);
        logic [XLEN-1:0] sh;
        sh = rdata >> {off, 3'b000};
        case (size)
            MEM_B:   return {{24{sh[7]}}, sh[7:0]};
            MEM_BU:  return {24'h0, sh[7:0]};
            MEM_H:   return {{16{sh[15]}}, sh[15:0]};
            MEM_HU:  return {16'h0, sh[15:0]};
            default: return sh;
        endcase
    endfunction

endpackage

// File: rtl/miriscv_memory_stage_if.sv
// Data-memory bus between the memory stage (master) and the memory system (slave).
interface miriscv_memory_stage_if;

    import miriscv_decode_pkg::*;

    // req is held with we/be/addr/wdata stable until gnt; one response (rvalid, rdata) follows each grant.
    logic              req;
    logic              we;
    logic [XLEN/8-1:0] be;
    logic [XLEN-1:0]   addr;
    logic [XLEN-1:0]   wdata;
    logic              gnt;
    logic              rvalid;
    logic [XLEN-1:0]   rdata;

    modport master (output req, we, be, addr, wdata, input gnt, rvalid, rdata);
    modport slave  (input req, we, be, addr, wdata, output gnt, rvalid, rdata);

endinterface

// File: rtl/miriscv_memory_stage_lsu.sv
// miriscv_lsu: bus FSM with byte enables and load alignment; one transaction outstanding.
// MIRISCV_MEM_MISALIGN_EXC_EN: misaligned H/W accesses are reported instead of issued.
module miriscv_lsu
    import miriscv_decode_pkg::*;
    import miriscv_lsu_pkg::*;
(
    input  logic                    clk_i,
    input  logic                    arstn_i,
    input  logic                    kill_i,
    input  logic                    mem_op_i,
    input  logic                    we_i,
    input  logic [MEM_ACCESS_W-1:0] size_i,
    input  logic [XLEN-1:0]         addr_i,
    input  logic [XLEN-1:0]         wdata_i,
    miriscv_memory_stage_if.master  data,
    output logic                    stall_o,
    output logic                    misalign_o,
    output logic [XLEN-1:0]         load_data_o,
    output lsu_state_t              state_o
);

    lsu_state_t              state_q, state_d;
    logic                    drain_q, drain_d;
    logic                    rq_we;
    logic [XLEN/8-1:0]       rq_be;
    logic [XLEN-1:0]         rq_addr, rq_wdata;
    logic [MEM_ACCESS_W-1:0] rq_size, rsp_size_q;
    logic [1:0]              rq_off, rsp_off_q;
    logic [1:0]              off;
    logic                    misaligned, issue;
    logic                    req_c, we_c;
    logic [XLEN/8-1:0]       be_c;
    logic [XLEN-1:0]         addr_c, wdata_c;

    assign off = lane_offset(size_i, addr_i[1:0]);

`ifdef MIRISCV_MEM_MISALIGN_EXC_EN
    assign misaligned = mem_op_i & is_misaligned(size_i, addr_i[1:0]);
`else
    assign misaligned = 1'b0;
`endif

    assign issue   = mem_op_i & ~kill_i & ~misaligned & ~drain_q;
    // A response arriving while draining belongs to a killed op and must not release a newer op.
    assign stall_o = mem_op_i & ~kill_i & ~misaligned
                   & ~((state_q == LSU_WAIT_RSP) & data.rvalid & ~drain_q);

    always_comb begin
        state_d = state_q;
        drain_d = drain_q;
        req_c   = 1'b0;
        we_c    = 1'b0;
        be_c    = '0;
        addr_c  = '0;
        wdata_c = '0;
        case (state_q)
            LSU_IDLE: begin
                if (issue) begin
                    req_c   = 1'b1;
                    we_c    = we_i;
                    be_c    = byte_enable(size_i, off);
                    addr_c  = {addr_i[XLEN-1:2], 2'b00};
                    wdata_c = store_data(size_i, wdata_i);
                    state_d = data.gnt ? LSU_WAIT_RSP : LSU_WAIT_GNT;
                end
            end
            LSU_WAIT_GNT: begin
                req_c   = 1'b1;
                we_c    = rq_we;
                be_c    = rq_be;
                addr_c  = rq_addr;
                wdata_c = rq_wdata;
                if (data.gnt) state_d = LSU_WAIT_RSP;
                if (kill_i)   drain_d = 1'b1;
            end
            LSU_WAIT_RSP: begin
                if (data.rvalid) begin
                    state_d = LSU_IDLE;
                    drain_d = 1'b0;
                end else if (kill_i) begin
                    drain_d = 1'b1;
                end
            end
            default: state_d = LSU_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge arstn_i) begin
        if (!arstn_i) begin
            state_q    <= LSU_IDLE;
            drain_q    <= 1'b0;
            rq_we      <= 1'b0;
            rq_be      <= '0;
            rq_addr    <= '0;
            rq_wdata   <= '0;
            rq_size    <= '0;
            rq_off     <= '0;
            rsp_size_q <= '0;
            rsp_off_q  <= '0;
        end else begin
            state_q <= state_d;
            drain_q <= drain_d;
            if ((state_q == LSU_IDLE) && issue) begin
                rq_we    <= we_c;
                rq_be    <= be_c;
                rq_addr  <= addr_c;
                rq_wdata <= wdata_c;
                rq_size  <= size_i;
                rq_off   <= off;
            end
            if ((state_q == LSU_IDLE) && issue && data.gnt) begin
                rsp_size_q <= size_i;
                rsp_off_q  <= off;
            end else if ((state_q == LSU_WAIT_GNT) && data.gnt) begin
                rsp_size_q <= rq_size;
                rsp_off_q  <= rq_off;
            end
        end
    end

    assign data.req    = req_c;
    assign data.we     = we_c;
    assign data.be     = be_c;
    assign data.addr   = addr_c;
    assign data.wdata  = wdata_c;
    assign misalign_o  = misaligned;
    assign load_data_o = load_align(rsp_size_q, rsp_off_q, data.rdata);
    assign state_o     = state_q;

endmodule

// File: rtl/miriscv_memory_stage.sv
// Memory stage: drives the LSU, resolves branch prediction, selects and registers writeback data.
// Misaligned-access reporting is enabled by MIRISCV_MEM_MISALIGN_EXC_EN (handled in miriscv_lsu).
module miriscv_memory_stage
    import miriscv_decode_pkg::*;
    import miriscv_lsu_pkg::*;
(
    input  logic                    clk_i,
    input  logic                    arstn_i,
    input  logic                    cu_kill_m_i,
    input  logic                    cu_stall_m_i,
    output logic                    m_stall_req_o,
    input  logic                    e_valid_i,
    input  logic [XLEN-1:0]         e_alu_result_i,
    input  logic [XLEN-1:0]         e_mdu_result_i,
    input  logic                    e_mem_req_i,
    input  logic                    e_mem_we_i,
    input  logic [MEM_ACCESS_W-1:0] e_mem_size_i,
    input  logic [XLEN-1:0]         e_mem_addr_i,
    input  logic [XLEN-1:0]         e_mem_data_i,
    input  logic                    e_gpr_wr_en_i,
    input  logic [GPR_ADDR_W-1:0]   e_gpr_wr_addr_i,
    input  logic [WB_SRC_W-1:0]     e_gpr_src_sel_i,
    input  logic                    e_branch_i,
    input  logic                    e_jal_i,
    input  logic                    e_jalr_i,
    input  logic [XLEN-1:0]         e_target_pc_i,
    input  logic [XLEN-1:0]         e_next_pc_i,
    input  logic                    e_prediction_i,
    input  logic                    e_br_j_taken_i,
    miriscv_memory_stage_if.master  data,
    output logic                    m_valid_o,
    output logic                    m_gpr_wr_en_o,
    output logic [GPR_ADDR_W-1:0]   m_gpr_wr_addr_o,
    output logic [XLEN-1:0]         m_gpr_wr_data_o,
    output logic                    m_prediction_err_o,
    output logic [XLEN-1:0]         m_new_pc_o,
    output logic                    m_misalign_o,
    output lsu_state_t              dbg_lsu_state_o
);

    logic            lsu_misalign;
    logic [XLEN-1:0] lsu_data;
    logic [XLEN-1:0] wb_data;
    logic            m_load;

    miriscv_lsu u_lsu (
        .clk_i       (clk_i),
        .arstn_i     (arstn_i),
        .kill_i      (cu_kill_m_i),
        .mem_op_i    (e_valid_i & e_mem_req_i),
        .we_i        (e_mem_we_i),
        .size_i      (e_mem_size_i),
        .addr_i      (e_mem_addr_i),
        .wdata_i     (e_mem_data_i),
        .data        (data),
        .stall_o     (m_stall_req_o),
        .misalign_o  (lsu_misalign),
        .load_data_o (lsu_data),
        .state_o     (dbg_lsu_state_o)
    );

    always_comb begin
        wb_data = e_alu_result_i;
        case (e_gpr_src_sel_i)
            MDU_DATA: wb_data = e_mdu_result_i;
            LSU_DATA: wb_data = lsu_data;
            default:  wb_data = e_alu_result_i;
        endcase
    end

    assign m_prediction_err_o = e_valid_i & (e_branch_i | e_jal_i | e_jalr_i)
                              & (e_prediction_i ^ e_br_j_taken_i);
    assign m_new_pc_o         = e_br_j_taken_i ? e_target_pc_i : e_next_pc_i;

    assign m_load = e_valid_i & ~m_stall_req_o;

    always_ff @(posedge clk_i or negedge arstn_i) begin
        if (!arstn_i) begin
            m_valid_o       <= 1'b0;
            m_gpr_wr_en_o   <= 1'b0;
            m_gpr_wr_addr_o <= '0;
            m_gpr_wr_data_o <= '0;
            m_misalign_o    <= 1'b0;
        end else if (cu_kill_m_i) begin
            m_valid_o <= 1'b0;
        end else if (!cu_stall_m_i) begin
            m_valid_o <= m_load;
            if (m_load) begin
                m_gpr_wr_en_o   <= e_gpr_wr_en_i & ~lsu_misalign;
                m_gpr_wr_addr_o <= e_gpr_wr_addr_i;
                m_gpr_wr_data_o <= wb_data;
                m_misalign_o    <= lsu_misalign;
            end
        end
    end

endmodule
